// File: rtl/rv_hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - default widths and the default load write-back select code
//   - forward-select encodings (FWD_RF / FWD_IM / FWD_WB)
//   - wait FSM state encoding
//   - packed stage-control payload
package rv_hazard_unit_pkg;

  localparam int unsigned RF_ADD_SIZE_DEF = 5;
  localparam int unsigned WB_SRC_W_DEF    = 3;
  localparam int unsigned PERF_W_DEF      = 32;
  localparam int unsigned TIMEOUT_DEF     = 64;

  localparam logic [WB_SRC_W_DEF-1:0] WB_SRC_LOAD_DEF = 3'd1;

  // Operand source selects driven towards the IE operand muxes
  localparam int unsigned FWD_W = 2;
  localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
  localparam logic [FWD_W-1:0] FWD_IM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_WB = 2'b01;

  typedef enum logic {
    HZ_IDLE = 1'b0,
    HZ_WAIT = 1'b1
  } hz_state_e;

  // Per-stage stall/flush controls
  typedef struct packed {
    logic if_stall;
    logic id_stall;
    logic id_flush;
    logic ie_stall;
    logic ie_flush;
    logic im_stall;
    logic iwb_flush;
  } hz_ctrl_t;

endpackage

// File: rtl/rv_hazard_unit_if.sv
// Bundle between the datapath and the hazard controller.
// Signal directions are named from the hazard controller's view:
//   i_* : pipeline register fields and memory handshake observed by the unit
//   o_* : stall / flush / forward selects, watchdog flag, perf counters
// modport master : datapath side (drives i_*, receives o_*)
// modport slave  : hazard controller side
interface rv_hazard_unit_if #(
  parameter int unsigned RF_ADD_SIZE = 5,
  parameter int unsigned WB_SRC_W    = 3,
  parameter int unsigned PERF_W      = 32
);

  logic [RF_ADD_SIZE-1:0] i_id_src_0;
  logic [RF_ADD_SIZE-1:0] i_id_src_1;
  logic [RF_ADD_SIZE-1:0] i_ie_src_0;
  logic [RF_ADD_SIZE-1:0] i_ie_src_1;
  logic [RF_ADD_SIZE-1:0] i_ie_dst;
  logic                   i_ie_we;
  logic [WB_SRC_W-1:0]    i_ie_wb_src;
  logic                   i_ie_nxt_pc_src;
  logic [RF_ADD_SIZE-1:0] i_im_dst;
  logic                   i_im_we;
  logic                   i_im_mem_req;
  logic                   i_dmem_ready;
  logic [RF_ADD_SIZE-1:0] i_iwb_dst;
  logic                   i_iwb_we;

  logic                   o_if_stall;
  logic                   o_id_stall;
  logic                   o_id_flush;
  logic                   o_ie_stall;
  logic                   o_ie_flush;
  logic                   o_im_stall;
  logic                   o_iwb_flush;
  logic [1:0]             o_ie_forward_0;
  logic [1:0]             o_ie_forward_1;
  logic                   o_mem_timeout;
  logic [PERF_W-1:0]      o_stall_cycles;
  logic [PERF_W-1:0]      o_flush_count;

  modport master (
    output i_id_src_0, i_id_src_1, i_ie_src_0, i_ie_src_1, i_ie_dst, i_ie_we,
           i_ie_wb_src, i_ie_nxt_pc_src, i_im_dst, i_im_we, i_im_mem_req,
           i_dmem_ready, i_iwb_dst, i_iwb_we,
    input  o_if_stall, o_id_stall, o_id_flush, o_ie_stall, o_ie_flush,
           o_im_stall, o_iwb_flush, o_ie_forward_0, o_ie_forward_1,
           o_mem_timeout, o_stall_cycles, o_flush_count
  );

  modport slave (
    input  i_id_src_0, i_id_src_1, i_ie_src_0, i_ie_src_1, i_ie_dst, i_ie_we,
           i_ie_wb_src, i_ie_nxt_pc_src, i_im_dst, i_im_we, i_im_mem_req,
           i_dmem_ready, i_iwb_dst, i_iwb_we,
    output o_if_stall, o_id_stall, o_id_flush, o_ie_stall, o_ie_flush,
           o_im_stall, o_iwb_flush, o_ie_forward_0, o_ie_forward_1,
           o_mem_timeout, o_stall_cycles, o_flush_count
  );

endinterface

// File: rtl/rv_hazard_unit_sat_counter.sv
// Saturating up-counter: +1 per cycle with i_inc high, sticks at all-ones.
// Ports: i_clk, i_rstn (async active-low), i_inc, o_count[W].
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count register; holds once every bit is set
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/rv_hazard_unit.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use
// bubble, branch flush and data-memory wait freeze, plus a bounded-wait
// watchdog and saturating perf counters.
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   hz_if (slave) : pipeline fields / dmem handshake in, stage controls,
//                   forward selects, o_mem_timeout and perf counters out
// Stage controls and forward selects are combinational from the current
// inputs; only the wait FSM, watchdog and counters are registered.
module rv_hazard_unit
  import rv_hazard_unit_pkg::*;
#(
  parameter int unsigned          RF_ADD_SIZE = RF_ADD_SIZE_DEF,
  parameter int unsigned          WB_SRC_W    = WB_SRC_W_DEF,
  parameter logic [WB_SRC_W-1:0]  WB_SRC_LOAD = WB_SRC_W'(WB_SRC_LOAD_DEF),
  parameter int unsigned          TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned          PERF_W      = PERF_W_DEF
) (
  input logic             i_clk,
  input logic             i_rstn,
  rv_hazard_unit_if.slave hz_if
);

  localparam int unsigned CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  hz_state_e        r_state;
  hz_state_e        w_state_nxt;
  hz_ctrl_t         w_ctrl;
  hz_ctrl_t         w_ctrl_gated;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;
  logic             w_mw;
  logic             w_br;
  logic             w_lu;
  logic [1:0]       w_fwd_0;
  logic [1:0]       w_fwd_1;

  // IM has priority over WB; x0 is never a forwarding source
  function automatic logic [1:0] fwd_sel(
    input logic [RF_ADD_SIZE-1:0] src,
    input logic [RF_ADD_SIZE-1:0] im_dst,
    input logic                   im_we,
    input logic [RF_ADD_SIZE-1:0] wb_dst,
    input logic                   wb_we
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (im_we && (im_dst != '0) && (im_dst == src)) begin
      sel = FWD_IM;
    end else if (wb_we && (wb_dst != '0) && (wb_dst == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  assign w_fwd_0 = fwd_sel(hz_if.i_ie_src_0, hz_if.i_im_dst, hz_if.i_im_we,
                           hz_if.i_iwb_dst, hz_if.i_iwb_we);
  assign w_fwd_1 = fwd_sel(hz_if.i_ie_src_1, hz_if.i_im_dst, hz_if.i_im_we,
                           hz_if.i_iwb_dst, hz_if.i_iwb_we);

  // Hazard conditions
  assign w_mw = hz_if.i_im_mem_req && !hz_if.i_dmem_ready;
  assign w_br = hz_if.i_ie_nxt_pc_src && !w_mw;
  assign w_lu = hz_if.i_ie_we && (hz_if.i_ie_wb_src == WB_SRC_LOAD) &&
                (hz_if.i_ie_dst != '0) &&
                ((hz_if.i_ie_dst == hz_if.i_id_src_0) ||
                 (hz_if.i_ie_dst == hz_if.i_id_src_1));

  // Wait FSM state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= HZ_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and stage controls; MW > BR > LU. A held LU or branch
  // re-asserts naturally once the memory wait drops.
  always_comb begin
    w_state_nxt = r_state;
    w_ctrl      = '0;

    case (r_state)
      HZ_IDLE: if (w_mw) w_state_nxt = HZ_WAIT;
      HZ_WAIT: if (hz_if.i_dmem_ready || !hz_if.i_im_mem_req) w_state_nxt = HZ_IDLE;
      default: w_state_nxt = HZ_IDLE;
    endcase

    if (w_mw) begin
      w_ctrl.if_stall  = 1'b1;
      w_ctrl.id_stall  = 1'b1;
      w_ctrl.ie_stall  = 1'b1;
      w_ctrl.im_stall  = 1'b1;
      w_ctrl.iwb_flush = 1'b1;
    end else if (w_br) begin
      // ID instruction is discarded, so no load-use stall is needed
      w_ctrl.id_flush  = 1'b1;
      w_ctrl.ie_flush  = 1'b1;
    end else if (w_lu) begin
      w_ctrl.if_stall  = 1'b1;
      w_ctrl.id_stall  = 1'b1;
      w_ctrl.ie_flush  = 1'b1;
    end
  end

  // Wait counter: zero in IDLE, counts cycles spent in WAIT, saturates
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wait_cnt <= '0;
    end else if (w_state_nxt == HZ_IDLE) begin
      r_wait_cnt <= '0;
    end else if ((r_state == HZ_WAIT) && (r_wait_cnt != CNT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // Sticky watchdog flag; the pipe keeps waiting after it sets
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_timeout <= 1'b0;
    end else if ((r_state == HZ_WAIT) && (r_wait_cnt == CNT_MAX)) begin
      r_timeout <= 1'b1;
    end
  end

  // Controls are held low while reset is asserted
  assign w_ctrl_gated = i_rstn ? w_ctrl : '0;

  assign hz_if.o_if_stall     = w_ctrl_gated.if_stall;
  assign hz_if.o_id_stall     = w_ctrl_gated.id_stall;
  assign hz_if.o_id_flush     = w_ctrl_gated.id_flush;
  assign hz_if.o_ie_stall     = w_ctrl_gated.ie_stall;
  assign hz_if.o_ie_flush     = w_ctrl_gated.ie_flush;
  assign hz_if.o_im_stall     = w_ctrl_gated.im_stall;
  assign hz_if.o_iwb_flush    = w_ctrl_gated.iwb_flush;
  assign hz_if.o_ie_forward_0 = i_rstn ? w_fwd_0 : FWD_RF;
  assign hz_if.o_ie_forward_1 = i_rstn ? w_fwd_1 : FWD_RF;
  assign hz_if.o_mem_timeout  = r_timeout;

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_inc   (w_ctrl_gated.if_stall),
    .o_count (hz_if.o_stall_cycles)
  );

  sat_counter #(.W(PERF_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_inc   (w_ctrl_gated.ie_flush),
    .o_count (hz_if.o_flush_count)
  );

endmodule

// File: tb/tb_rv_hazard_unit.sv
// Self-checking bench for rv_hazard_unit: table of combinational vectors
// followed by multi-cycle sequences (load-use, memory wait, branch held
// through a wait, watchdog, mid-wait reset). Expected values go into a
// scoreboard queue when a vector is driven and are popped at the negedge.
module tb_rv_hazard_unit;
  import rv_hazard_unit_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned SW = 3;
  localparam int unsigned PW = 4;   // small so stall counter saturation is reached
  localparam int unsigned TO = 4;

  // Expected control word: {if_st,id_st,id_fl,ie_st,ie_fl,im_st,iwb_fl,fwd0,fwd1}
  localparam logic [10:0] E_NONE = 11'b0000000_00_00;
  localparam logic [10:0] E_LU   = 11'b1100100_00_00;
  localparam logic [10:0] E_BR   = 11'b0010100_00_00;
  localparam logic [10:0] E_MW   = 11'b1101011_00_00;
  localparam logic [10:0] F0_IM  = 11'b0000000_10_00;
  localparam logic [10:0] F0_WB  = 11'b0000000_01_00;
  localparam logic [10:0] F1_WB  = 11'b0000000_00_01;

  typedef struct packed {
    logic [AW-1:0] id_src_0;
    logic [AW-1:0] id_src_1;
    logic [AW-1:0] ie_src_0;
    logic [AW-1:0] ie_src_1;
    logic [AW-1:0] ie_dst;
    logic          ie_we;
    logic [SW-1:0] ie_wb_src;
    logic          br;
    logic [AW-1:0] im_dst;
    logic          im_we;
    logic          mem_req;
    logic          ready;
    logic [AW-1:0] wb_dst;
    logic          wb_we;
  } stim_t;

  typedef struct {
    string       name;
    stim_t       in;
    logic [10:0] exp;
  } vec_t;

  typedef struct {
    string         name;
    logic [10:0]   ctrl;
    logic          to;
    logic [PW-1:0] stall;
    logic [PW-1:0] flush;
  } sb_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [PW-1:0] m_stall;
  logic [PW-1:0] m_flush;
  logic          m_to;
  sb_t           sb_q[$];
  vec_t          vecs[$];

  rv_hazard_unit_if #(.RF_ADD_SIZE(AW), .WB_SRC_W(SW), .PERF_W(PW)) hz_if ();

  rv_hazard_unit #(
    .RF_ADD_SIZE (AW),
    .WB_SRC_W    (SW),
    .WB_SRC_LOAD (3'd1),
    .TIMEOUT     (TO),
    .PERF_W      (PW)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rst_n),
    .hz_if  (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic stim_t idle();
    stim_t x;
    x = '0;
    x.ready = 1'b1;
    return x;
  endfunction

  function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
    return (v == {PW{1'b1}}) ? v : v + PW'(1);
  endfunction

  task automatic drive(input stim_t s);
    hz_if.i_id_src_0      = s.id_src_0;
    hz_if.i_id_src_1      = s.id_src_1;
    hz_if.i_ie_src_0      = s.ie_src_0;
    hz_if.i_ie_src_1      = s.ie_src_1;
    hz_if.i_ie_dst        = s.ie_dst;
    hz_if.i_ie_we         = s.ie_we;
    hz_if.i_ie_wb_src     = s.ie_wb_src;
    hz_if.i_ie_nxt_pc_src = s.br;
    hz_if.i_im_dst        = s.im_dst;
    hz_if.i_im_we         = s.im_we;
    hz_if.i_im_mem_req    = s.mem_req;
    hz_if.i_dmem_ready    = s.ready;
    hz_if.i_iwb_dst       = s.wb_dst;
    hz_if.i_iwb_we        = s.wb_we;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] ctrl_now();
    return {hz_if.o_if_stall, hz_if.o_id_stall, hz_if.o_id_flush,
            hz_if.o_ie_stall, hz_if.o_ie_flush, hz_if.o_im_stall,
            hz_if.o_iwb_flush, hz_if.o_ie_forward_0, hz_if.o_ie_forward_1};
  endfunction

  // Pop the oldest expectation and compare all observable outputs
  task automatic check_out();
    sb_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({e.name, ".ctrl"},    32'(ctrl_now()),             32'(e.ctrl));
      chk({e.name, ".timeout"}, 32'(hz_if.o_mem_timeout),    32'(e.to));
      chk({e.name, ".stalls"},  32'(hz_if.o_stall_cycles),   32'(e.stall));
      chk({e.name, ".flushes"}, 32'(hz_if.o_flush_count),    32'(e.flush));
    end
  endtask

  // One vector for one clock: drive after posedge, check at negedge.
  // Counters seen at the negedge include all earlier vectors only.
  task automatic step(input string nm, input stim_t s, input logic [10:0] e);
    sb_t item;
    @(posedge clk);
    #1;
    drive(s);
    item.name  = nm;
    item.ctrl  = e;
    item.to    = m_to;
    item.stall = m_stall;
    item.flush = m_flush;
    sb_q.push_back(item);
    @(negedge clk);
    check_out();
    if (e[10]) m_stall = sat_inc(m_stall);
    if (e[6])  m_flush = sat_inc(m_flush);
  endtask

  task automatic add(input string nm, input stim_t s, input logic [10:0] e);
    vec_t v;
    v.name = nm;
    v.in   = s;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, ".ctrl"},    32'(ctrl_now()),           32'd0);
    chk({nm, ".timeout"}, 32'(hz_if.o_mem_timeout),  32'd0);
    chk({nm, ".stalls"},  32'(hz_if.o_stall_cycles), 32'd0);
    chk({nm, ".flushes"}, 32'(hz_if.o_flush_count),  32'd0);
  endtask

  initial begin
    stim_t st;
    stim_t lu;
    n_vec   = 0;
    n_err   = 0;
    m_stall = '0;
    m_flush = '0;
    m_to    = 1'b0;

    // Reset held with hazard-producing inputs: everything must read zero
    st = idle();
    st.br = 1'b1;
    st.ie_src_0 = 5'd5; st.im_dst = 5'd5; st.im_we = 1'b1;
    drive(st);
    rst_n = 1'b0;
    #2;
    check_reset_state("reset_hold");
    #5 rst_n = 1'b1;
    drive(idle());

    // ---------------- table vectors ----------------
    add("idle", idle(), E_NONE);

    st = idle(); st.ie_src_0 = 5'd5;
    st.im_dst = 5'd5; st.im_we = 1'b1; st.wb_dst = 5'd5; st.wb_we = 1'b1;
    add("fwd_im_over_wb", st, F0_IM);
    st.im_we = 1'b0;
    add("fwd_wb", st, F0_WB);
    st = idle(); st.im_we = 1'b1; st.wb_we = 1'b1;
    add("fwd_x0", st, E_NONE);

    st = idle(); st.ie_src_1 = 5'd9; st.wb_dst = 5'd9; st.wb_we = 1'b1;
    st.im_dst = 5'd3; st.im_we = 1'b1;
    add("fwd1_wb", st, F1_WB);
    st.ie_src_0 = 5'd3;
    add("fwd_both", st, F0_IM | F1_WB);

    lu = idle(); lu.ie_we = 1'b1; lu.ie_wb_src = 3'd1; lu.ie_dst = 5'd7;
    lu.id_src_1 = 5'd7;
    add("lu_src1", lu, E_LU);
    st = lu; st.id_src_1 = 5'd2; st.id_src_0 = 5'd7;
    add("lu_src0", st, E_LU);
    st = lu; st.ie_wb_src = 3'd0;
    add("no_lu_alu", st, E_NONE);
    st = lu; st.ie_dst = 5'd0; st.id_src_1 = 5'd0;
    add("no_lu_x0", st, E_NONE);
    st = lu; st.ie_we = 1'b0;
    add("no_lu_we0", st, E_NONE);

    st = idle(); st.br = 1'b1;
    add("branch", st, E_BR);
    st = lu; st.br = 1'b1;
    add("branch_over_lu", st, E_BR);

    st = idle(); st.mem_req = 1'b1; st.ready = 1'b0;
    add("mw_1", st, E_MW);
    st.ready = 1'b1;
    add("mw_1_ready", st, E_NONE);
    st = lu; st.br = 1'b1; st.mem_req = 1'b1; st.ready = 1'b0;
    add("mw_over_br_lu", st, E_MW);
    st.mem_req = 1'b0; st.ready = 1'b1;
    add("br_lu_after_mw", st, E_BR);
    st = idle(); st.mem_req = 1'b1; st.ready = 1'b0;
    st.ie_src_0 = 5'd5; st.im_dst = 5'd5; st.im_we = 1'b1;
    add("mw_fwd", st, E_MW | F0_IM);
    add("mw_fwd_exit", idle(), E_NONE);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].name, vecs[i].in, vecs[i].exp);
    end

    // ---------------- load-use: single bubble ----------------
    step("lu_seq", lu, E_LU);
    step("lu_seq_after", idle(), E_NONE);

    // ---------------- memory wait: 3 cycles then ready ----------------
    st = idle(); st.mem_req = 1'b1; st.ready = 1'b0;
    for (int i = 0; i < 3; i++) step("mw3_wait", st, E_MW);
    st.ready = 1'b1;
    step("mw3_ready", st, E_NONE);
    step("mw3_done", idle(), E_NONE);

    // ---------------- branch held through a wait ----------------
    st = idle(); st.mem_req = 1'b1; st.ready = 1'b0; st.br = 1'b1;
    for (int i = 0; i < 3; i++) step("mwbr_wait", st, E_MW);
    st.ready = 1'b1;
    step("mwbr_ready", st, E_BR);
    step("mwbr_done", idle(), E_NONE);

    // Another short wait: watchdog must not fire if the counter cleared
    st = idle(); st.mem_req = 1'b1; st.ready = 1'b0;
    for (int i = 0; i < 3; i++) step("mw3b_wait", st, E_MW);
    st.ready = 1'b1;
    step("mw3b_ready", st, E_NONE);
    step("mw3b_done", idle(), E_NONE);

    // ---------------- watchdog: ready low for 6 cycles ----------------
    st = idle(); st.mem_req = 1'b1; st.ready = 1'b0;
    for (int i = 0; i < 5; i++) step("wd_wait", st, E_MW);
    m_to = 1'b1;   // four cycles spent in WAIT by now
    step("wd_wait_to", st, E_MW);
    st.ready = 1'b1;
    step("wd_ready", st, E_NONE);
    step("wd_sticky", idle(), E_NONE);

    // ---------------- asynchronous reset mid-wait ----------------
    st = idle(); st.mem_req = 1'b1; st.ready = 1'b0;
    step("rst_wait_0", st, E_MW);
    step("rst_wait_1", st, E_MW);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_mid_wait");
    m_stall = '0;
    m_flush = '0;
    m_to    = 1'b0;
    drive(idle());
    #1 rst_n = 1'b1;

    // After reset: counters restart and a short wait does not time out
    step("post_rst_idle", idle(), E_NONE);
    st = idle(); st.mem_req = 1'b1; st.ready = 1'b0;
    for (int i = 0; i < 3; i++) step("post_rst_wait", st, E_MW);
    st.ready = 1'b1;
    step("post_rst_ready", st, E_NONE);
    step("post_rst_lu", lu, E_LU);
    step("post_rst_done", idle(), E_NONE);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv_hazard_unit.md
Name: rv_hazard_unit

Overview:
- Parametrised successor to the 5-stage core's hazard controller; drives all stall, flush and forward-select signals for IF/ID/IE/IM/WB.
- Adds three things the current controller lacks:
  - a data-memory wait handshake (`i_dmem_ready`), so multi-cycle memories freeze the pipe;
  - a bounded-wait watchdog;
  - saturating performance counters.
- Sits beside the datapath. Stage-control outputs are combinational from current inputs and state.

Parameters:
- RF_ADD_SIZE, 5, register-file address width.
- WB_SRC_W, 3, width of the write-back source select.
- WB_SRC_LOAD, 3'd1, write-back select code meaning "load from data memory".
- TIMEOUT, 64, wait cycles before `o_mem_timeout` sets; must be ≥ 2.
- PERF_W, 32, performance-counter width.

Ports:
- i_clk in 1 clock
- i_rstn in 1 asynchronous active-low reset
- i_id_src_0 in RF_ADD_SIZE rs1 of instruction in ID
- i_id_src_1 in RF_ADD_SIZE rs2 of instruction in ID
- i_ie_src_0 in RF_ADD_SIZE rs1 in IE
- i_ie_src_1 in RF_ADD_SIZE rs2 in IE
- i_ie_dst in RF_ADD_SIZE rd in IE
- i_ie_we in 1 IE writes RF
- i_ie_wb_src in WB_SRC_W IE write-back select
- i_ie_nxt_pc_src in 1 taken branch/jump resolved in IE
- i_im_dst in RF_ADD_SIZE rd in IM
- i_im_we in 1 IM writes RF
- i_im_mem_req in 1 IM holds a load or store
- i_dmem_ready in 1 data memory completes the access this cycle
- i_iwb_dst in RF_ADD_SIZE rd in WB
- i_iwb_we in 1 WB writes RF
- o_if_stall out 1 hold PC
- o_id_stall out 1 hold IF/ID register
- o_id_flush out 1 clear IF/ID register
- o_ie_stall out 1 hold ID/IE register
- o_ie_flush out 1 clear ID/IE register
- o_im_stall out 1 hold IE/IM register
- o_iwb_flush out 1 clear IM/WB register (bubble)
- o_ie_forward_0 out 2 rs1 select: 00 RF, 10 IM ALU result, 01 WB data
- o_ie_forward_1 out 2 rs2 select, same encoding
- o_mem_timeout out 1 sticky watchdog flag
- o_stall_cycles out PERF_W cycles with `o_if_stall` high
- o_flush_count out PERF_W count of `o_ie_flush` assertions

Behaviour:
- Reset (`i_rstn` low, asynchronous):
  - FSM → IDLE; wait counter, perf counters and `o_mem_timeout` → 0.
  - While reset is held, all stall, flush and forward outputs are forced to 0.
- Forwarding (combinational):
  - IM has priority over WB.
  - Forward from a stage only when that stage's `we` is 1, its dst is nonzero, and dst equals the IE source.
  - Register x0 is never forwarded.
- Load-use (LU):
  - Condition: `i_ie_we` && `i_ie_wb_src`==WB_SRC_LOAD && `i_ie_dst`≠0 && dst equals `i_id_src_0` or `i_id_src_1`.
  - Response: `o_if_stall`=`o_id_stall`=1, `o_ie_flush`=1. Exactly one bubble.
- Memory wait (MW):
  - Condition: `i_im_mem_req` && !`i_dmem_ready`.
  - Response: `o_if_stall`, `o_id_stall`, `o_ie_stall`, `o_im_stall` = 1 and `o_iwb_flush`=1.
  - All other flushes are forced to 0. Any pending LU or branch is held and re-evaluated after MW ends.
- Branch (BR):
  - Condition: `i_ie_nxt_pc_src` && !MW.
  - Response: `o_id_flush`=`o_ie_flush`=1.
  - BR overrides LU stalls: `o_if_stall`=`o_id_stall`=0, because the ID instruction is discarded.
- Priority order: MW > BR > LU.
- FSM states: IDLE, WAIT.
  - IDLE→WAIT when MW is true.
  - WAIT→IDLE when `i_dmem_ready`=1 or `i_im_mem_req`=0.
  - A ready in the first cycle produces no stall and no state change.
- Wait counter:
  - Clears on entry to IDLE; increments each cycle in WAIT.
  - When it reaches TIMEOUT−1, `o_mem_timeout` sets and stays set until reset.
  - The counter saturates; the pipe keeps waiting.
- Perf counters:
  - Each increments by 1 per qualifying cycle and saturates at all-ones; no wrap-around.
- Latency: stage-control outputs take effect in the same cycle; registered state updates on the next rising edge.

Decomposition:
- Shared package/header holds:
  - forward-select encodings `FWD_RF`, `FWD_IM`, `FWD_WB`;
  - FSM state encodings `HZ_IDLE`, `HZ_WAIT`;
  - the default WB_SRC_LOAD code, alongside the existing width macros.
- One natural sub-module, `sat_counter` (parameter W, inputs `i_clk`, `i_rstn`, `i_inc`), instantiated twice for the perf counters.

Test Plan:
- Dependent forwarding:
  - Stimulus: IE rs1=5; IM dst=5, we=1; WB dst=5, we=1.
  - Required: `o_ie_forward_0`=10. With IM we=0 instead: 01. With dst=0: 00.
- Load-use:
  - Stimulus: IE load with dst=7 (wb_src=1, we=1), ID src_1=7.
  - Required: `o_if_stall`=`o_id_stall`=`o_ie_flush`=1 for 1 cycle; `o_flush_count`=1 afterwards.
- Branch overriding LU:
  - Stimulus: `i_ie_nxt_pc_src`=1 together with the LU condition.
  - Required: `o_id_flush`=`o_ie_flush`=1, `o_if_stall`=0.
- Memory wait:
  - Stimulus: `i_im_mem_req`=1, `i_dmem_ready` low for 3 cycles, then high.
  - Required: all four stalls plus `o_iwb_flush` high for 3 cycles; `o_stall_cycles`=3; FSM returns to IDLE.
  - With a branch asserted in IE during the wait: flushes stay 0 until the ready cycle, then assert.
- Watchdog:
  - Stimulus: TIMEOUT=4, ready held low for 6 cycles.
  - Required: `o_mem_timeout` rises after 4 cycles in WAIT and stays high after ready.
  - An asynchronous reset mid-wait clears the flag, counters and FSM immediately.
